// File: rtl/afifo_write_arbiter.sv
// ============================================================================
//  Module      : afifo_write_arbiter
//  Description : Round-robin burst arbiter for the async FIFO write port, with
//                toggle-handshake flush sequencing. Optional burst header word
//                enabled by defining AFIFO_ARB_HDR_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module afifo_write_arbiter #(
  parameter int W   = 16,
  parameter int R   = 4,
  parameter int IDW = $clog2(R)
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic [R-1:0]     req_valid,
  input  logic [R*W-1:0]   req_data,
  input  logic [R-1:0]     req_last,
  output logic [R-1:0]     req_ready,
  input  logic             flush_req,
  output logic             flush_busy,
  output logic [IDW-1:0]   grant_id,
  output logic             busy,
  output logic             fifo_rst,
  input  logic             fifo_rst_done,
  output logic             fifo_w_trigger,
  output logic [W-1:0]     fifo_w_data,
  input  logic             fifo_w_ready
);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_BURST      = 3'd1,
    S_FLUSH      = 3'd2,
    S_FLUSH_WAIT = 3'd3
`ifdef AFIFO_ARB_HDR_EN
    , S_HDR      = 3'd4
`endif
  } state_t;

  localparam logic [IDW-1:0] c_last_id = IDW'(R - 1);

  state_t         r_state;
  state_t         w_state_nxt;
  logic [IDW-1:0] r_ptr;
  logic [IDW-1:0] r_grant;
  logic           r_pend;
  logic           r_fifo_rst;
  logic           r_done_q;

  logic [W-1:0]   w_data_arr [R];
  logic [R-1:0]   w_rot;
  logic [IDW-1:0] w_off;
  logic [IDW:0]   w_sum;
  logic [IDW-1:0] w_sel;
  logic           w_found;
  logic           w_grant_load;
  logic           w_last_beat;
  logic           w_flush_done;
  logic [IDW-1:0] w_ptr_inc;

  for (genvar gi = 0; gi < R; gi++) begin : g_unpack
    assign w_data_arr[gi] = req_data[gi*W +: W];
  end

  // Rotate the valids so bit 0 is the pointer position, then take the lowest set bit.
  always_comb begin
    w_rot   = R'({req_valid, req_valid} >> r_ptr);
    w_found = 1'b0;
    w_off   = '0;
    for (int k = R - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        w_found = 1'b1;
        w_off   = IDW'(k);
      end
    end
    w_sum = {1'b0, r_ptr} + {1'b0, w_off};
    w_sel = (w_sum >= (IDW+1)'(R)) ? IDW'(w_sum - (IDW+1)'(R)) : IDW'(w_sum);
  end

  assign w_ptr_inc  = (r_grant == c_last_id) ? '0 : r_grant + IDW'(1);
  assign busy       = (r_state != S_IDLE);
  assign flush_busy = r_pend;
  assign grant_id   = r_grant;
  assign fifo_rst   = r_fifo_rst;

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    req_ready      = '0;
    fifo_w_trigger = 1'b0;
    fifo_w_data    = w_data_arr[r_grant];
    w_grant_load   = 1'b0;
    w_last_beat    = 1'b0;
    w_flush_done   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_pend) begin
          w_state_nxt = S_FLUSH;
        end else if (w_found) begin
          w_grant_load = 1'b1;
`ifdef AFIFO_ARB_HDR_EN
          w_state_nxt  = S_HDR;
`else
          w_state_nxt  = S_BURST;
`endif
        end
      end
`ifdef AFIFO_ARB_HDR_EN
      S_HDR: begin
        fifo_w_trigger = fifo_w_ready;
        fifo_w_data    = W'(r_grant);
        if (fifo_w_ready) begin
          w_state_nxt = S_BURST;
        end
      end
`endif
      S_BURST: begin
        req_ready[r_grant] = fifo_w_ready;
        fifo_w_trigger     = req_valid[r_grant] & fifo_w_ready;
        if (req_valid[r_grant] && fifo_w_ready && req_last[r_grant]) begin
          w_last_beat = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      S_FLUSH: begin
        w_state_nxt = S_FLUSH_WAIT;
      end
      S_FLUSH_WAIT: begin
        if (fifo_rst_done != r_done_q) begin
          w_flush_done = 1'b1;
          w_state_nxt  = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_ptr      <= '0;
      r_grant    <= '0;
      r_pend     <= 1'b0;
      r_fifo_rst <= 1'b0;
      r_done_q   <= 1'b0;
    end else begin
      r_done_q <= fifo_rst_done;
      if (w_grant_load) begin
        r_grant <= w_sel;
      end
      if (w_last_beat) begin
        r_ptr <= w_ptr_inc;
      end
      // Completion clears the flag; pulses arriving while pending merge into it.
      if (w_flush_done) begin
        r_pend <= 1'b0;
      end else if (flush_req) begin
        r_pend <= 1'b1;
      end
      if (r_state == S_FLUSH) begin
        r_fifo_rst <= ~r_fifo_rst;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_afifo_write_arbiter.sv
// ============================================================================
//  Module      : tb_afifo_write_arbiter
//  Description : Scoreboard bench for afifo_write_arbiter (header-aware when
//                AFIFO_ARB_HDR_EN is defined).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_afifo_write_arbiter;

  localparam int W   = 16;
  localparam int R   = 4;
  localparam int IDW = 2;
`ifdef AFIFO_ARB_HDR_EN
  localparam int C_HDR = 1;
`else
  localparam int C_HDR = 0;
`endif

  logic           clk = 1'b0;
  logic           rst_;
  logic [R-1:0]   req_valid;
  logic [R*W-1:0] req_data;
  logic [R-1:0]   req_last;
  logic [R-1:0]   req_ready;
  logic           flush_req;
  logic           flush_busy;
  logic [IDW-1:0] grant_id;
  logic           busy;
  logic           fifo_rst;
  logic           fifo_rst_done;
  logic           fifo_w_trigger;
  logic [W-1:0]   fifo_w_data;
  logic           fifo_w_ready;

  afifo_write_arbiter #(.W(W), .R(R), .IDW(IDW)) u_dut (
    .clk            (clk),
    .rst_           (rst_),
    .req_valid      (req_valid),
    .req_data       (req_data),
    .req_last       (req_last),
    .req_ready      (req_ready),
    .flush_req      (flush_req),
    .flush_busy     (flush_busy),
    .grant_id       (grant_id),
    .busy           (busy),
    .fifo_rst       (fifo_rst),
    .fifo_rst_done  (fifo_rst_done),
    .fifo_w_trigger (fifo_w_trigger),
    .fifo_w_data    (fifo_w_data),
    .fifo_w_ready   (fifo_w_ready)
  );

  always #5 clk = ~clk;

  int           n_vec  = 0;
  int           n_miss = 0;
  int           wr_cnt = 0;
  int           rst_tog = 0;
  int           seq = 1;
  logic         rst_prev = 1'b0;
  logic [W-1:0] exp_q [$];
  logic [W:0]   src_q [R][$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Queue a burst on requester id and record the words the FIFO must receive.
  task automatic load(input int id, input int n);
    logic [W-1:0] d;
`ifdef AFIFO_ARB_HDR_EN
    exp_q.push_back(W'(id));
`endif
    for (int k = 0; k < n; k++) begin
      d = {4'(id), 12'(seq)};
      seq++;
      src_q[id].push_back({(k == n - 1), d});
      exp_q.push_back(d);
    end
  endtask

  task automatic wait_wr(input int target, input string tag);
    int k = 0;
    while (wr_cnt < target && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk(tag, 32'(wr_cnt >= target), 1);
  endtask

  task automatic wait_empty(input string tag);
    int k = 0;
    while (exp_q.size() != 0 && k < 300) begin
      @(negedge clk);
      k++;
    end
    chk(tag, exp_q.size(), 0);
  endtask

  task automatic wait_tog(input int tog0, input string tag);
    int k = 0;
    while (rst_tog == tog0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk(tag, rst_tog - tog0, 1);
  endtask

  task automatic pulse_flush();
    @(posedge clk); #1 flush_req = 1'b1;
    @(posedge clk); #1 flush_req = 1'b0;
  endtask

  // Producer model: present queue heads, retire a word once it was accepted.
  initial begin
    logic [R-1:0] acc;
    logic [W:0]   head;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    forever begin
      @(negedge clk);
      acc = req_valid & req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < R; i++) begin
        if (acc[i]) void'(src_q[i].pop_front());
        if (src_q[i].size() > 0) begin
          head = src_q[i][0];
          req_valid[i]         = 1'b1;
          req_last[i]          = head[W];
          req_data[i*W +: W]   = head[W-1:0];
        end else begin
          req_valid[i] = 1'b0;
          req_last[i]  = 1'b0;
        end
      end
    end
  end

  // FIFO write-side monitor and scoreboard.
  always @(negedge clk) begin
    if (rst_) begin
      if (fifo_w_trigger) begin
        if (exp_q.size() == 0) chk("wr_unexpected", fifo_w_trigger, 0);
        else chk("wr_data", fifo_w_data, exp_q.pop_front());
        wr_cnt++;
      end
      if (fifo_rst != rst_prev) rst_tog++;
      rst_prev = fifo_rst;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int tog0;
    rst_          = 1'b0;
    flush_req     = 1'b0;
    fifo_rst_done = 1'b0;
    fifo_w_ready  = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_flush_busy", flush_busy, 0);
    chk("rst_grant_id", grant_id, 0);
    chk("rst_busy", busy, 0);
    chk("rst_fifo_rst", fifo_rst, 0);
    chk("rst_trigger", fifo_w_trigger, 0);
    @(posedge clk); #1 rst_ = 1'b1;

    // Lone 3-word burst from requester 2
    @(negedge clk);
    load(2, 3);
    @(negedge clk);
    chk("t1_bubble_trig", fifo_w_trigger, 0);
    chk("t1_bubble_busy", busy, 0);
    for (int k = 0; k < 3 + C_HDR; k++) begin
      @(negedge clk);
      chk("t1_grant", grant_id, 2);
      chk("t1_trig", fifo_w_trigger, 1);
      chk("t1_busy", busy, 1);
    end
    @(negedge clk);
    chk("t1_idle", busy, 0);
    wait_empty("t1_drain");

    // Requesters 0,1,3 with 1-word bursts; pointer is 3 after the previous burst
    @(negedge clk);
    for (int r = 0; r < 2; r++) begin
      load(3, 1);
      load(0, 1);
      load(1, 1);
    end
    wait_empty("t2_drain");

    // FIFO full for 5 cycles mid-burst of requester 1
    @(negedge clk);
    base = wr_cnt;
    load(1, 6);
    wait_wr(base + C_HDR + 2, "t3_start");
    @(posedge clk); #1 fifo_w_ready = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("t3_stall_rdy", req_ready[1], 0);
      chk("t3_stall_trig", fifo_w_trigger, 0);
    end
    @(posedge clk); #1 fifo_w_ready = 1'b1;
    @(negedge clk);
    chk("t3_resume_rdy", req_ready[1], 1);
    wait_empty("t3_drain");

    // Flush during a 4-word burst of requester 0; requester 1 waits through it
    @(negedge clk);
    base = wr_cnt;
    tog0 = rst_tog;
    load(0, 4);
    wait_wr(base + C_HDR + 1, "t4_start");
    pulse_flush();
    @(negedge clk);
    chk("t4_fbusy_set", flush_busy, 1);
    load(1, 1);
    wait_tog(tog0, "t4_rst_tog");
    chk("t4_fifo_rst", fifo_rst, 1);
    chk("t4_burst_done", wr_cnt - base, 4 + C_HDR);
    repeat (4) begin
      @(negedge clk);
      chk("t4_hold_trig", fifo_w_trigger, 0);
      chk("t4_hold_rdy", req_ready, 0);
      chk("t4_hold_fbusy", flush_busy, 1);
    end
    @(posedge clk); #1 fifo_rst_done = ~fifo_rst_done;
    @(negedge clk);
    @(negedge clk);
    chk("t4_fbusy_clr", flush_busy, 0);
    wait_empty("t4_drain");

    // Two flush pulses 3 cycles apart merge into one fifo_rst toggle
    @(negedge clk);
    base = wr_cnt;
    tog0 = rst_tog;
    load(2, 6);
    wait_wr(base + C_HDR + 1, "t5_start");
    pulse_flush();
    @(posedge clk);
    pulse_flush();
    wait_tog(tog0, "t5_rst_tog");
    @(posedge clk); #1 fifo_rst_done = ~fifo_rst_done;
    repeat (6) @(negedge clk);
    chk("t5_one_toggle", rst_tog - tog0, 1);
    chk("t5_fifo_rst", fifo_rst, 0);
    chk("t5_fbusy_clr", flush_busy, 0);
    chk("t5_words", wr_cnt - base, 6 + C_HDR);

    // Single-word burst from requester 3 (header 16'h0003 first when enabled)
    @(negedge clk);
    load(3, 1);
    wait_empty("t6_drain");
    @(negedge clk);
    chk("t6_idle", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

`default_nettype wire
